// File: rtl/seq_det_pkg.sv
// Shared limits and helpers for the serial pattern detector.
// Pure constants and functions, with no timing or flow control of their own.
package seq_det_pkg;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;

  // Largest value a cnt_w-bit counter can hold before it must stick.
  function automatic longint unsigned sat_value(input int cnt_w);
    return (64'd1 << cnt_w) - 64'd1;
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating event counter; one cycle from inc to count, sticks at all-ones.
// Always accepts inc; clr beats inc and Reset beats both.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_value(CNT_W));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: y is a zero-latency Mealy flag, match_count is registered (1 cycle).
// No backpressure: a bit is consumed in every cycle with en=1, and en=0 freezes the detector.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               en,
  input  logic               x,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               cnt_clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_count
);

  localparam int FILL_W = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);

  generate
    if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_pat_len
      $error("seq_detector_param: PAT_LEN out of range 2..16");
    end
  endgenerate

  logic [PAT_LEN-1:0] pat;
  logic [PAT_LEN-2:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [PAT_LEN-1:0] window;

  assign window = {hist, x};
  assign y = en & ~pat_load & ~Reset & (fill == FILL_LAST) & (window == pat);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pat  <= PATTERN;
      hist <= '0;
      fill <= '0;
    end else if (pat_load) begin
      pat  <= pat_in;
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= window[PAT_LEN-2:0];
      // Non-overlapping mode restarts the window so the next hit needs fresh bits.
      if (!OVERLAP && y) begin
        fill <= '0;
      end else if (fill != FILL_LAST) begin
        fill <= fill + 1'b1;
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .Clock(Clock),
    .Reset(Reset),
    .inc  (y),
    .clr  (cnt_clr),
    .count(match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Drives three detector variants (overlap, non-overlap, 2-bit counter) from one stimulus
// and compares them against a stream/window reference model.
module tb_seq_detector_param;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       en = 1'b0;
  logic       x = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0;
  logic       cnt_clr = 1'b0;
  logic       y_w [3];
  logic [7:0] mc0, mc1;
  logic [1:0] mc2;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
    .Clock(Clock), .Reset(Reset), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .y(y_w[0]), .match_count(mc0));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_nov (
    .Clock(Clock), .Reset(Reset), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .y(y_w[1]), .match_count(mc1));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c2 (
    .Clock(Clock), .Reset(Reset), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .y(y_w[2]), .match_count(mc2));

  // Reference model: every accepted bit since the last reset/load, plus per-variant
  // index where the current fresh window began.
  bit         stream[$];
  int         start[3];
  int         cnt[3];
  logic [3:0] m_pat;
  bit         yrec[3];
  int         maxc[3] = '{255, 255, 3};
  bit         ovl[3]  = '{1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit e, input bit xv, input bit ld, input logic [3:0] pin,
                      input bit clr, input bit rst);
    bit ey[3];
    int n;
    logic [3:0] w;
    en = e; x = xv; pat_load = ld; pat_in = pin; cnt_clr = clr; Reset = rst;
    #3;
    n = stream.size();
    w = 4'b0;
    if (n >= 3) w = {stream[n-3], stream[n-2], stream[n-1], xv};
    for (int i = 0; i < 3; i++) begin
      ey[i] = e && !ld && !rst && (n - start[i] + 1 >= 4) && (w == m_pat);
      yrec[i] = y_w[i];
    end
    check("y_ov", {31'b0, y_w[0]}, {31'b0, ey[0]});
    check("y_nov", {31'b0, y_w[1]}, {31'b0, ey[1]});
    check("y_c2", {31'b0, y_w[2]}, {31'b0, ey[2]});
    if (rst) begin
      stream.delete();
      start = '{0, 0, 0};
      cnt = '{0, 0, 0};
      m_pat = 4'b1011;
    end else begin
      if (ld) begin
        m_pat = pin;
        stream.delete();
        start = '{0, 0, 0};
      end else if (e) begin
        stream.push_back(xv);
        for (int i = 0; i < 3; i++)
          if (ey[i] && !ovl[i]) start[i] = stream.size();
      end
      for (int i = 0; i < 3; i++) begin
        if (clr) cnt[i] = 0;
        else if (ey[i] && cnt[i] < maxc[i]) cnt[i] = cnt[i] + 1;
      end
    end
    @(posedge Clock);
    #1;
    check("cnt_ov", {24'b0, mc0}, cnt[0]);
    check("cnt_nov", {24'b0, mc1}, cnt[1]);
    check("cnt_c2", {30'b0, mc2}, cnt[2]);
  endtask

  task automatic feed(input bit b);
    step(1'b1, b, 1'b0, 4'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0]  v7a, v7b;
    logic [3:0]  v4;
    logic [4:0]  v5;
    logic [15:0] s16;
    #1;
    do_reset();
    do_reset();
    check("reset_cnt", {24'b0, mc0}, 0);

    // Overlapping vs non-overlapping on 1,0,1,1,0,1,1.
    v7a = '0; v7b = '0;
    s16 = 16'b1011011_000000000;
    for (int k = 0; k < 7; k++) begin
      feed(s16[15-k]);
      v7a = {v7a[5:0], yrec[0]};
      v7b = {v7b[5:0], yrec[1]};
    end
    check("ovl_y_bits", {25'b0, v7a}, 32'b0001001);
    check("novl_y_bits", {25'b0, v7b}, 32'b0001000);
    check("ovl_count", {24'b0, mc0}, 2);
    check("novl_count", {24'b0, mc1}, 1);

    // Fill guard with an all-zero pattern.
    do_reset();
    step(1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    v4 = '0;
    for (int k = 0; k < 3; k++) begin
      feed(1'b0);
      v4 = {v4[2:0], yrec[0]};
    end
    check("fill_guard", {28'b0, v4}, 0);
    feed(1'b0);
    check("zero_pat_hit", {31'b0, yrec[0]}, 1);

    // en=0 cycle is ignored.
    do_reset();
    v5 = '0;
    feed(1'b1); v5 = {v5[3:0], yrec[0]};
    feed(1'b0); v5 = {v5[3:0], yrec[0]};
    step(1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0); v5 = {v5[3:0], yrec[0]};
    feed(1'b1); v5 = {v5[3:0], yrec[0]};
    feed(1'b1); v5 = {v5[3:0], yrec[0]};
    check("en_gap", {27'b0, v5}, 32'b00001);

    // Counter saturation, then clear winning over a match.
    do_reset();
    s16 = 16'b1011011011011011;
    for (int k = 0; k < 16; k++) feed(s16[15-k]);
    check("sat_c2", {30'b0, mc2}, 3);
    check("five_ov", {24'b0, mc0}, 5);
    feed(1'b0);
    feed(1'b1);
    step(1'b1, 1'b1, 1'b0, 4'b0, 1'b1, 1'b0);
    check("clr_match_y", {31'b0, yrec[2]}, 1);
    check("clr_wins", {30'b0, mc2}, 0);

    // Pattern load mid-stream discards history and its own x.
    do_reset();
    feed(1'b1); feed(1'b0); feed(1'b1);
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
    feed(1'b1);
    check("load_no_y", {31'b0, yrec[0]}, 0);
    v4 = '0;
    s16 = 16'b0110_000000000000;
    for (int k = 0; k < 4; k++) begin
      feed(s16[15-k]);
      v4 = {v4[2:0], yrec[0]};
    end
    check("load_hit", {28'b0, v4}, 32'b0001);

    // Random traffic with occasional reset, load and clear.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 7) != 0, 1'($urandom),
           $urandom_range(0, 59) == 0, 4'($urandom),
           $urandom_range(0, 79) == 0, $urandom_range(0, 149) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
